// File: rtl/pwr_timer_multi_pkg.sv
// Shared definitions for the power-off timer bank: opcodes and command-word layout.
package pwr_timer_multi_pkg;

  typedef enum logic [1:0] {
    OP_LOAD_ONESHOT = 2'b00,
    OP_LOAD_WDOG    = 2'b01,
    OP_KICK         = 2'b10,
    OP_CANCEL       = 2'b11
  } op_t;

  localparam int unsigned CMD_W  = 24;
  localparam int unsigned OP_MSB = 23;
  localparam int unsigned OP_LSB = 22;
  localparam int unsigned CH_MSB = 21;
  localparam int unsigned CH_LSB = 20;

endpackage

// File: rtl/pwr_timer_chan.sv
// One timer channel: one-shot or watchdog countdown with a sticky expired flag.
module pwr_timer_chan
  import pwr_timer_multi_pkg::*;
#(
  parameter int unsigned CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  logic          cmd_en,
  input  op_t           op,
  input  logic [CW-1:0] val,
  output logic [CW-1:0] count,
  output logic          armed,
  output logic          expired
);

  logic [CW-1:0] reload;
  logic          wdog;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count   <= '0;
      reload  <= '0;
      wdog    <= 1'b0;
      armed   <= 1'b0;
      expired <= 1'b0;
    end else if (!expired) begin
      // A command on a tick cycle takes priority and this channel skips that tick.
      if (cmd_en) begin
        case (op)
          OP_LOAD_ONESHOT: begin
            count  <= val;
            reload <= '0;
            wdog   <= 1'b0;
            armed  <= (val != '0);
          end
          OP_LOAD_WDOG: begin
            count  <= val;
            reload <= val;
            wdog   <= 1'b1;
            armed  <= (val != '0);
          end
          OP_KICK: begin
            if (wdog) count <= reload;
          end
          OP_CANCEL: begin
            armed <= 1'b0;
            count <= '0;
          end
          default: ;
        endcase
      end else if (tick && armed && (count != '0)) begin
        if (count == CW'(1)) begin
          count   <= '0;
          armed   <= 1'b0;
          expired <= 1'b1;
        end else begin
          count <= count - CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/pwr_timer_multi.sv
// Multi-channel countdown timer bank; any expired channel latches the power-off request.
module pwr_timer_multi
  import pwr_timer_multi_pkg::*;
#(
  parameter int unsigned NCH  = 4,
  parameter int unsigned CW   = 16,
  parameter int unsigned DIV  = 5000000,
  parameter int unsigned WARN = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CMD_W-1:0] in_data,
  input  logic             in_wr,
  output logic             pwr_off,
  output logic [NCH-1:0]   expired,
  output logic [NCH-1:0]   warn
);

  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] WARN_C = CW'(WARN);

  logic [PW-1:0] pre;
  logic          tick;
  op_t           cmd_op;
  logic [1:0]    cmd_ch;
  logic [CW-1:0] cmd_val;
  logic [NCH-1:0] cmd_en;
  logic [NCH-1:0] armed;
  logic [CW-1:0]  count [NCH];
  logic           unused_bits;

  // Free-running divider; commands never resynchronise it.
  assign tick = (pre == PW'(DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       pre <= '0;
    else if (tick) pre <= '0;
    else           pre <= pre + PW'(1);
  end

  assign cmd_op      = op_t'(in_data[OP_MSB:OP_LSB]);
  assign cmd_ch      = in_data[CH_MSB:CH_LSB];
  assign cmd_val     = in_data[CW-1:0];
  assign unused_bits = ^in_data[CH_LSB-1:CW];

  // Channel selects at or above NCH match no instance and are dropped.
  for (genvar i = 0; i < NCH; i++) begin : g_chan
    assign cmd_en[i] = in_wr && (cmd_ch == 2'(i));

    pwr_timer_chan #(.CW(CW)) u_chan (
      .clk     (clk),
      .rst     (rst),
      .tick    (tick),
      .cmd_en  (cmd_en[i]),
      .op      (cmd_op),
      .val     (cmd_val),
      .count   (count[i]),
      .armed   (armed[i]),
      .expired (expired[i])
    );

    assign warn[i] = armed[i] && (count[i] <= WARN_C);
  end

  assign pwr_off = |expired;

endmodule
